// File: rtl/mcs_pkg.sv
// Shared types and constants for the multicycle stage sequencer.
// Provides the state enum, the stage index map and the state-to-stage-enable decode.
package mcs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF,
        ST_ID,
        ST_EX,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_ERR
    } seqState_t;

    localparam int NUM_STAGES = 5;
    localparam int STG_IF     = 0;
    localparam int STG_ID     = 1;
    localparam int STG_EX     = 2;
    localparam int STG_MEM    = 3;
    localparam int STG_WB     = 4;

    // Non-stage states (IDLE/HALT/ERR) decode to all zeros.
    function automatic logic [NUM_STAGES-1:0] stageOneHot(input seqState_t s);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        case (s)
            ST_IF:   oh[STG_IF]  = 1'b1;
            ST_ID:   oh[STG_ID]  = 1'b1;
            ST_EX:   oh[STG_EX]  = 1'b1;
            ST_MEM:  oh[STG_MEM] = 1'b1;
            ST_WB:   oh[STG_WB]  = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mcs_wait_timer.sv
// Counts consecutive cycles with an outstanding, un-acknowledged memory request.
// timeout fires combinationally on the WAIT_MAX-th such cycle.
module mcs_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic req,
    input  logic ack,
    output logic timeout
);

    localparam int TW = $clog2(WAIT_MAX + 1);

    logic [TW-1:0] waitCnt;
    logic          waiting;

    assign waiting = req & ~ack;
    assign timeout = waiting && (waitCnt == TW'(WAIT_MAX - 1));

    always_ff @(posedge clock) begin
        if (!reset_n || clear || !waiting) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + TW'(1);
        end
    end

endmodule

// File: rtl/multicycle_stage_sequencer.sv
// One-hot IF/ID/EX/MEM/WB stage-enable sequencer with memory handshakes, halt and timeout error.
// Define SEQ_PERF_EN to add the cycle_cnt / stall_cnt performance counters.
module multicycle_stage_sequencer
    import mcs_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  jump,
    input  logic                  branch,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  reg_w,
    input  logic                  stop,
    input  logic                  imem_ack,
    input  logic                  dmem_ack,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  imem_req,
    output logic                  dmem_req,
    output logic                  pc_we,
    output logic                  rf_we,
    output logic                  halted,
    output logic                  err,
    output logic [CNT_W-1:0]      retired
`ifdef SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    seqState_t state;
    seqState_t nextState;
    logic      pcWe;
    logic      rfWe;
    logic      reqActive;
    logic      ackActive;
    logic      timeout;

    assign stage_en  = stageOneHot(state);
    assign imem_req  = (state == ST_IF);
    assign dmem_req  = (state == ST_MEM);
    assign halted    = (state == ST_HALT);
    assign err       = (state == ST_ERR);
    assign pc_we     = pcWe;
    assign rf_we     = rfWe;

    // One timer serves both fetch and data waits since they never overlap.
    assign reqActive = imem_req | dmem_req;
    assign ackActive = (imem_req & imem_ack) | (dmem_req & dmem_ack);

    mcs_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) uWaitTimer (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (nextState != state),
        .req     (reqActive),
        .ack     (ackActive),
        .timeout (timeout)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        pcWe      = 1'b0;
        rfWe      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) nextState = ST_IF;
            end
            ST_IF: begin
                if (imem_ack)     nextState = ST_ID;
                else if (timeout) nextState = ST_ERR;
            end
            ST_ID: begin
                if (stop) begin
                    nextState = ST_HALT;
                end else if (jump) begin
                    pcWe      = 1'b1;
                    nextState = ST_IF;
                end else begin
                    nextState = ST_EX;
                end
            end
            ST_EX: begin
                if (branch) begin
                    pcWe      = 1'b1;
                    nextState = ST_IF;
                end else if (mem_read && mem_write) begin
                    nextState = ST_ERR;
                end else if (mem_read || mem_write) begin
                    nextState = ST_MEM;
                end else if (reg_w) begin
                    nextState = ST_WB;
                end else begin
                    pcWe      = 1'b1;
                    nextState = ST_IF;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (mem_read && reg_w) begin
                        nextState = ST_WB;
                    end else begin
                        pcWe      = 1'b1;
                        nextState = ST_IF;
                    end
                end else if (timeout) begin
                    nextState = ST_ERR;
                end
            end
            ST_WB: begin
                rfWe      = reg_w;
                pcWe      = 1'b1;
                nextState = ST_IF;
            end
            ST_HALT: nextState = ST_HALT;
            ST_ERR:  nextState = ST_ERR;
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            retired <= '0;
        end else if (pcWe) begin
            retired <= retired + CNT_W'(1);
        end
    end

`ifdef SEQ_PERF_EN
    logic running;
    assign running = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_ERR);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (running)                  cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (reqActive && !ackActive)  stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_stage_sequencer.sv
// Randomized bench: per-instruction expected cycle traces are derived from the stage/latency rules
// and compared every cycle against the sequencer outputs.
module tb_multicycle_stage_sequencer;

    localparam int CNT_W    = 32;
    localparam int WAIT_MAX = 15;

    localparam int C_JUMP = 0, C_BRANCH = 1, C_ALUWB = 2, C_ALU = 3, C_STORE = 4;
    localparam int C_LOADWB = 5, C_LOAD = 6, C_STOP = 7, C_ILLEGAL = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             jump = 1'b0, branch = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic             reg_w = 1'b0, stop = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [4:0]       stage_en;
    logic             imem_req, dmem_req, pc_we, rf_we, halted, err;
    logic [CNT_W-1:0] retired;
`ifdef SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_cnt, stall_cnt;
    int               expCycles = 0, expStalls = 0;
`endif

    int total = 0;
    int bad = 0;
    int expRetired = 0;

    multicycle_stage_sequencer #(
        .CNT_W    (CNT_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .jump      (jump),
        .branch    (branch),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .reg_w     (reg_w),
        .stop      (stop),
        .imem_ack  (imem_ack),
        .dmem_ack  (dmem_ack),
        .stage_en  (stage_en),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .pc_we     (pc_we),
        .rf_we     (rf_we),
        .halted    (halted),
        .err       (err),
        .retired   (retired)
`ifdef SEQ_PERF_EN
        ,
        .cycle_cnt (cycle_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic randomCtl();
        jump = rbit(); branch = rbit(); mem_read = rbit();
        mem_write = rbit(); reg_w = rbit(); stop = rbit();
    endtask

    // One clock cycle: drive acks/start, check every output against the expected values, advance.
    task automatic stepCycle(input string tag, input logic [4:0] stg, input logic ireq, input logic dreq,
                             input logic pcwe, input logic rfwe, input logic hlt, input logic er,
                             input logic iack, input logic dack, input logic st);
        start    = st;
        imem_ack = ireq ? iack : rbit();
        dmem_ack = dreq ? dack : rbit();
        @(negedge clock);
        checkEq({tag, ".stage_en"}, 32'(stage_en), 32'(stg));
        checkEq({tag, ".imem_req"}, 32'(imem_req), 32'(ireq));
        checkEq({tag, ".dmem_req"}, 32'(dmem_req), 32'(dreq));
        checkEq({tag, ".pc_we"}, 32'(pc_we), 32'(pcwe));
        checkEq({tag, ".rf_we"}, 32'(rf_we), 32'(rfwe));
        checkEq({tag, ".halted"}, 32'(halted), 32'(hlt));
        checkEq({tag, ".err"}, 32'(err), 32'(er));
        checkEq({tag, ".retired"}, retired, 32'(expRetired));
`ifdef SEQ_PERF_EN
        checkEq({tag, ".cycle_cnt"}, cycle_cnt, 32'(expCycles));
        checkEq({tag, ".stall_cnt"}, stall_cnt, 32'(expStalls));
        if (stg != 5'b0) expCycles++;
        if ((ireq && !iack) || (dreq && !dack)) expStalls++;
`endif
        if (pcwe) expRetired++;
        @(posedge clock);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clock);
        checkEq({tag, ".stage_en"}, 32'(stage_en), 32'd0);
        checkEq({tag, ".imem_req"}, 32'(imem_req), 32'd0);
        checkEq({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
        checkEq({tag, ".pc_we"}, 32'(pc_we), 32'd0);
        checkEq({tag, ".rf_we"}, 32'(rf_we), 32'd0);
        checkEq({tag, ".halted"}, 32'(halted), 32'd0);
        checkEq({tag, ".err"}, 32'(err), 32'd0);
        checkEq({tag, ".retired"}, retired, 32'd0);
    endtask

    // Two reset edges, then release and leave the sequencer idle for one cycle.
    task automatic doReset(input string tag);
        reset_n = 1'b0;
        start   = 1'b0;
        randomCtl();
        @(posedge clock); #1;
        checkIdle({tag, ".r1"});
        @(posedge clock); #1;
        checkIdle({tag, ".r2"});
        reset_n    = 1'b1;
        expRetired = 0;
`ifdef SEQ_PERF_EN
        expCycles = 0;
        expStalls = 0;
`endif
        @(posedge clock); #1;
    endtask

    task automatic startStep();
        randomCtl();
        stepCycle("idle", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Runs one instruction of class cls; dI/dD are ack delays in cycles after the request.
    // abortMem >= 0 returns before that MEM cycle is executed.
    task automatic runInstr(input int cls, input int dI, input int dD, input int abortMem);
        logic j, b, rd, wr, rw, stp;
        j = 1'b0; b = 1'b0; rd = 1'b0; wr = 1'b0; rw = 1'b0; stp = 1'b0;
        case (cls)
            C_JUMP:    begin j = 1'b1; b = rbit(); rd = rbit(); wr = rbit(); rw = rbit(); end
            C_BRANCH:  begin b = 1'b1; rd = rbit(); wr = rbit(); rw = rbit(); end
            C_ALUWB:   rw = 1'b1;
            C_STORE:   begin wr = 1'b1; rw = rbit(); end
            C_LOADWB:  begin rd = 1'b1; rw = 1'b1; end
            C_LOAD:    rd = 1'b1;
            C_STOP:    begin stp = 1'b1; j = rbit(); end
            C_ILLEGAL: begin rd = 1'b1; wr = 1'b1; rw = rbit(); end
            default:   ;
        endcase
        for (int k = 0; k <= dI; k++) begin
            randomCtl();
            stepCycle("if", 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, (k == dI), 1'b0, rbit());
        end
        jump = j; branch = b; mem_read = rd; mem_write = wr; reg_w = rw; stop = stp;
        stepCycle("id", 5'b00010, 1'b0, 1'b0, j && !stp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rbit());
        if (stp || j) return;
        jump = rbit(); stop = rbit();
        stepCycle("ex", 5'b00100, 1'b0, 1'b0, b || (!rd && !wr && !rw), 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, rbit());
        if (b || (!rd && !wr && !rw) || (rd && wr)) return;
        if (rd || wr) begin
            for (int k = 0; k <= dD; k++) begin
                if (abortMem >= 0 && k == abortMem) return;
                stepCycle("mem", 5'b01000, 1'b0, 1'b1, (k == dD) && !(rd && rw), 1'b0, 1'b0, 1'b0,
                          1'b0, (k == dD), rbit());
            end
            if (!(rd && rw)) return;
        end
        stepCycle("wb", 5'b10000, 1'b0, 1'b0, 1'b1, rw, 1'b0, 1'b0, 1'b0, 1'b0, rbit());
    endtask

    task automatic stuckCycles(input string tag, input logic hlt, input logic er);
        for (int k = 0; k < 5; k++) begin
            randomCtl();
            stepCycle(tag, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, hlt, er, 1'b1, 1'b1, 1'b1);
        end
    endtask

    function automatic int pickDelay();
        return ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        doReset("init");
        startStep();
        runInstr(C_LOADWB, 0, 10, 3);
        doReset("midmem");
        startStep();

        runInstr(C_ALUWB, 0, 0, -1);
        runInstr(C_LOADWB, 0, 3, -1);
        runInstr(C_JUMP, 0, 0, -1);
        runInstr(C_STORE, 2, WAIT_MAX - 1, -1);
        runInstr(C_ALU, WAIT_MAX - 1, 0, -1);

        for (int n = 0; n < 150; n++) begin
            runInstr(int'($urandom_range(C_JUMP, C_LOAD)), pickDelay(), pickDelay(), -1);
        end

        runInstr(C_BRANCH, 1, 0, -1);
        runInstr(C_STOP, 1, 0, -1);
        stuckCycles("halt", 1'b1, 1'b0);
        doReset("afterhalt");
        startStep();

        runInstr(C_ALUWB, 0, 0, -1);
        for (int k = 0; k < WAIT_MAX; k++) begin
            randomCtl();
            stepCycle("iftmo", 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        stuckCycles("ierr", 1'b0, 1'b1);
        doReset("afterierr");
        startStep();

        runInstr(C_LOAD, 1, 0, 0);
        for (int k = 0; k < WAIT_MAX; k++) begin
            stepCycle("memtmo", 5'b01000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        stuckCycles("derr", 1'b0, 1'b1);
        doReset("afterderr");
        startStep();

        runInstr(C_ILLEGAL, 0, 0, -1);
        stuckCycles("illegal", 1'b0, 1'b1);
        doReset("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
